snake_body: RTL and testbench

- Game-logic producer of the snake position list consumed by the grid renderer.
- Each position is one byte: row in bits [7:4], column in bits [3:0], on a 16x16 field. pos[0] is the head.
- On each game tick the block takes the requested direction and grow flag, and runs a sequential self-collision scan over the body.
- It then shifts the body one cell forward, or flags the snake dead.

---
 rtl/snake_body.sv | 195 +++++++++++++++++++
 tb/tb_snake_body.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body.sv
// snake_body: keeps the snake position list (pos[0] = head) on a 16x16 field.
// A tick filters the heading, scans the body for self-collision, then commits a move or death.
module snake_body #(
  parameter int         MAX_LEN   = 255,
  parameter int         INIT_LEN  = 3,
  parameter logic [7:0] INIT_HEAD = 8'h88,
  parameter bit         WRAP      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [1:0]        dir,
  input  logic              grow,
  output logic [255:0][7:0] pos,
  output logic [7:0]        length,
  output logic              busy,
  output logic              done,
  output logic              dead
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    MOVE = 2'd2
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state_r, state_s;
  logic [1:0] heading_r, heading_s;
  logic       grow_r;
  logic [7:0] next_head_r;
  logic       wall_r;
  logic [7:0] scan_limit_r, scan_limit_s;
  logic [7:0] idx_r;
  logic       hit_r;
  logic       commit_r;   // MOVE decision is applied on the following edge
  logic       accept_s;
  logic       hit_s;
  logic       can_grow_s;
  logic [8:0] step_s;     // {left_field, next_head}

  // One step of the head in 4-bit row/column space; MSB flags a wrap across an edge.
  function automatic logic [8:0] step_head(input logic [7:0] head, input logic [1:0] hd);
    logic [3:0] row;
    logic [3:0] col;
    logic       at_edge;
    row = head[7:4];
    col = head[3:0];
    case (hd)
      DIR_UP: begin
        at_edge = (row == 4'd0);
        row     = row - 4'd1;
      end
      DIR_RIGHT: begin
        at_edge = (col == 4'd15);
        col     = col + 4'd1;
      end
      DIR_DOWN: begin
        at_edge = (row == 4'd15);
        row     = row + 4'd1;
      end
      DIR_LEFT: begin
        at_edge = (col == 4'd0);
        col     = col - 4'd1;
      end
      default: begin
        at_edge = 1'b0;
      end
    endcase
    return {at_edge, row, col};
  endfunction

  // Tick acceptance, reversal filter, next-head and scan-window computation
  always_comb begin
    accept_s = (state_r == IDLE) && tick && !dead && !busy;
    if (dir == (heading_r ^ 2'd2)) begin
      heading_s = heading_r;
    end else begin
      heading_s = dir;
    end
    step_s     = step_head(pos[0], heading_s);
    can_grow_s = grow && (length < MAX_LEN_B);
    // a non-growing step frees the tail cell, so the tail is left out of the scan
    if (can_grow_s) begin
      scan_limit_s = length;
    end else begin
      scan_limit_s = length - 8'd1;
    end
    hit_s = (pos[idx_r] == next_head_r);
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (scan_limit_s == 8'd0) begin
            state_s = MOVE;
          end else begin
            state_s = SCAN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (hit_s || (idx_r == scan_limit_r - 8'd1)) begin
          state_s = MOVE;
        end else begin
          state_s = SCAN;
        end
      end
      MOVE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Step datapath: latch the request, run the scan, commit the move or the death
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        pos[i] <= (i < INIT_LEN) ? INIT_HEAD - 8'(i) : 8'h00;
      end
      length       <= 8'(INIT_LEN);
      heading_r    <= DIR_RIGHT;
      grow_r       <= 1'b0;
      next_head_r  <= 8'h00;
      wall_r       <= 1'b0;
      scan_limit_r <= 8'd0;
      idx_r        <= 8'd0;
      hit_r        <= 1'b0;
      commit_r     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      dead         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (commit_r) begin
            commit_r <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            if (hit_r || wall_r) begin
              dead <= 1'b1;
            end else begin
              for (int i = 255; i > 0; i--) begin
                pos[i] <= pos[i-1];
              end
              pos[0] <= next_head_r;
              if (grow_r) begin
                length <= length + 8'd1;
              end
            end
          end else if (accept_s) begin
            heading_r    <= heading_s;
            grow_r       <= can_grow_s;
            next_head_r  <= step_s[7:0];
            wall_r       <= step_s[8] & ~WRAP;
            scan_limit_r <= scan_limit_s;
            idx_r        <= 8'd0;
            hit_r        <= 1'b0;
            busy         <= 1'b1;
          end
        end
        SCAN: begin
          hit_r <= hit_s;
          idx_r <= idx_r + 8'd1;
        end
        MOVE: begin
          commit_r <= 1'b1;
        end
        default: begin
          commit_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body.sv
// Bench for snake_body: directed plan steps plus random walks, checked against a list model.
// dut_a runs with WRAP=1 and dut_b with WRAP=0; both see the same stimulus.
module tb_snake_body;

  typedef logic [255:0][7:0] body_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [1:0]  dir;
  logic        grow;
  body_t       pos_a, pos_b;
  logic [7:0]  len_a, len_b;
  logic        busy_a, busy_b, done_a, done_b, dead_a, dead_b;

  int n_cmp = 0;
  int n_bad = 0;
  int n_step = 0;

  // reference model: one body list per instance, index 0 = head
  logic [7:0] mb [2][256];
  int         mlen [2];
  int         mhd [2];
  bit         mdead [2];

  always #5 clk = ~clk;

  snake_body #(.WRAP(1'b1)) dut_a (
    .clk(clk), .reset(reset), .tick(tick), .dir(dir), .grow(grow),
    .pos(pos_a), .length(len_a), .busy(busy_a), .done(done_a), .dead(dead_a)
  );

  snake_body #(.WRAP(1'b0)) dut_b (
    .clk(clk), .reset(reset), .tick(tick), .dir(dir), .grow(grow),
    .pos(pos_b), .length(len_b), .busy(busy_b), .done(done_b), .dead(dead_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input body_t obs, input body_t exp);
    int j;
    j = 0;
    n_cmp++;
    assert (obs === exp) else begin
      for (int i = 255; i >= 0; i--) begin
        if (obs[i] !== exp[i]) j = i;
      end
      n_bad++;
      $error("FAIL %s: pos[%0d] observed %0h expected %0h", tag, j, obs[j], exp[j]);
    end
  endtask

  function automatic body_t model_pos(input int k);
    body_t b;
    for (int i = 0; i < 256; i++) b[i] = mb[k][i];
    return b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) mb[k][i] = (i < 3) ? 8'(136 - i) : 8'h00;
      mlen[k]  = 3;
      mhd[k]   = 1;
      mdead[k] = 1'b0;
    end
  endtask

  // Apply one tick to the model; lat = expected busy cycles (0 when the tick is ignored).
  task automatic model_step(input int k, input int d, input bit g, output int lat);
    int eff, r, c, dr, dc, chk_n, hitj;
    bit wall, gg;
    logic [7:0] h, nh;
    lat = 0;
    if (mdead[k]) return;
    eff = (d == ((mhd[k] + 2) % 4)) ? mhd[k] : d;
    mhd[k] = eff;
    h = mb[k][0];
    r = int'(h[7:4]);
    c = int'(h[3:0]);
    dr = 0;
    dc = 0;
    case (eff)
      0: dr = -1;
      1: dc = 1;
      2: dr = 1;
      default: dc = -1;
    endcase
    r = r + dr;
    c = c + dc;
    wall = (r < 0) || (r > 15) || (c < 0) || (c > 15);
    r = (r + 16) % 16;
    c = (c + 16) % 16;
    nh = 8'(r * 16 + c);
    gg = g && (mlen[k] < 255);
    chk_n = gg ? mlen[k] : mlen[k] - 1;
    hitj = -1;
    for (int j = 0; j < chk_n; j++) begin
      if (hitj < 0 && mb[k][j] == nh) hitj = j;
    end
    if (hitj >= 0) begin
      mdead[k] = 1'b1;
      lat = hitj + 3;
    end else begin
      lat = chk_n + 2;
      if (wall && k == 1) begin
        mdead[k] = 1'b1;
      end else begin
        for (int i = 255; i > 0; i--) mb[k][i] = mb[k][i-1];
        mb[k][0] = nh;
        if (gg) mlen[k] = mlen[k] + 1;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Issue one tick, watch busy/done until every live instance finishes, then compare.
  task automatic do_step(input int d, input bit g);
    int lat [2];
    int nbusy [2];
    int ndone [2];
    bit fin;
    n_step++;
    for (int k = 0; k < 2; k++) begin
      model_step(k, d, g, lat[k]);
      nbusy[k] = 0;
      ndone[k] = 0;
    end
    tick = 1'b1;
    dir  = 2'(d);
    grow = g;
    @(posedge clk);
    #1;
    tick = 1'b0;
    dir  = 2'($urandom_range(0, 3));
    grow = 1'($urandom_range(0, 1));
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      nbusy[0] += int'(busy_a);
      nbusy[1] += int'(busy_b);
      ndone[0] += int'(done_a);
      ndone[1] += int'(done_b);
      fin = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (lat[k] == 0 ? (cyc < 4) : (ndone[k] == 0)) fin = 1'b0;
      end
      if (fin) break;
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("s%0d_busy%0d", n_step, k), 32'(nbusy[k]), 32'(lat[k]));
      chk($sformatf("s%0d_done%0d", n_step, k), 32'(ndone[k]), (lat[k] > 0) ? 32'd1 : 32'd0);
      chk_pos($sformatf("s%0d_pos%0d", n_step, k), (k == 0) ? pos_a : pos_b, model_pos(k));
      chk($sformatf("s%0d_len%0d", n_step, k), (k == 0) ? 32'(len_a) : 32'(len_b), 32'(mlen[k]));
      chk($sformatf("s%0d_dead%0d", n_step, k), (k == 0) ? 32'(dead_a) : 32'(dead_b), 32'(mdead[k]));
    end
  endtask

  initial begin
    int dcount;
    dir  = 2'd0;
    grow = 1'b0;
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_p0", 32'(pos_a[0]), 32'h88);
    chk("rst_p1", 32'(pos_a[1]), 32'h87);
    chk("rst_p2", 32'(pos_a[2]), 32'h86);
    chk("rst_len", 32'(len_a), 32'd3);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_dead", 32'(dead_a), 32'd0);
    chk_pos("rst_pos_b", pos_b, model_pos(1));

    // single step right
    do_step(1, 1'b0);
    chk("right_p0", 32'(pos_a[0]), 32'h89);
    chk("right_p2", 32'(pos_a[2]), 32'h87);

    // grow down, then reversal filtered
    do_reset();
    do_step(2, 1'b1);
    chk("grow_p0", 32'(pos_a[0]), 32'h98);
    chk("grow_p3", 32'(pos_a[3]), 32'h86);
    chk("grow_len", 32'(len_a), 32'd4);
    do_step(0, 1'b0);
    chk("rev_p0", 32'(pos_a[0]), 32'hA8);

    // self-collision against the tail: legal without grow
    do_reset();
    do_step(1, 1'b0);
    do_step(2, 1'b1);
    do_step(3, 1'b0);
    do_step(0, 1'b0);
    chk("sq_p3", 32'(pos_a[3]), 32'h89);
    do_step(1, 1'b0);
    chk("sq_move_p0", 32'(pos_a[0]), 32'h89);
    chk("sq_move_dead", 32'(dead_a), 32'd0);

    // same with grow: fatal, sticky, further ticks ignored
    do_reset();
    do_step(1, 1'b0);
    do_step(2, 1'b1);
    do_step(3, 1'b0);
    do_step(0, 1'b0);
    do_step(1, 1'b1);
    chk("sq_grow_dead", 32'(dead_a), 32'd1);
    chk("sq_grow_p0", 32'(pos_a[0]), 32'h88);
    do_step(1, 1'b0);
    do_step(2, 1'b1);

    // right edge: wrap on dut_a, wall death on dut_b
    do_reset();
    repeat (7) do_step(1, 1'b0);
    chk("edge_p0", 32'(pos_a[0]), 32'h8F);
    do_step(1, 1'b0);
    chk("wrap_p0", 32'(pos_a[0]), 32'h80);
    chk("wall_dead", 32'(dead_b), 32'd1);
    chk("wall_p0", 32'(pos_b[0]), 32'h8F);

    // random walks with idle gaps (gap 0 ticks in the done cycle)
    for (int ep = 0; ep < 3; ep++) begin
      do_reset();
      for (int s = 0; s < 25; s++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_step($urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      end
    end

    // serpentine growth to saturation, then one more grow
    do_reset();
    repeat (7) do_step(1, 1'b1);
    for (int r = 0; r < 15; r++) begin
      do_step(2, 1'b1);
      repeat (15) do_step((r % 2 == 0) ? 3 : 1, 1'b1);
    end
    do_step(2, 1'b1);
    repeat (5) do_step(1, 1'b1);
    chk("sat_len", 32'(len_a), 32'd255);
    chk("sat_p0", 32'(pos_a[0]), 32'h85);

    // reset asserted in the middle of a long scan
    tick = 1'b1;
    dir  = 2'd1;
    grow = 1'b0;
    @(posedge clk);
    #1;
    tick = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", 32'(busy_a), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk_pos("mid_rst_pos", pos_a, model_pos(0));
    chk("mid_rst_len", 32'(len_a), 32'd3);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_done", 32'(done_a), 32'd0);
    chk("mid_rst_dead_b", 32'(dead_b), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    repeat (10) begin
      @(negedge clk);
      dcount += int'(done_a) + int'(busy_a);
    end
    chk("mid_no_done", 32'(dcount), 32'd0);
    do_step(1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
